cpu_ifetch: RTL and testbench
=============================

# cpu_ifetch

Instruction fetch unit for the 8-bit core. It sits directly upstream of the decoder and is driven by the CPU control FSM through `ifetch_en`, `pc_reset` and `pc_branch`. It owns the program counter, reads variable-length instructions (1–3 bytes) one byte at a time from a synchronous instruction memory, and hands each assembled instruction to the decoder with a valid/ack handshake.

## Interface
Parameters:
- `ADDR_W`, default 12: instruction address width.
- `RESET_VEC`, default 0: PC value after reset or `pc_reset`.

Ports:
- `clk`, input, 1: the single clock; everything is sampled on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `ifetch_en`, input, 1: permission to issue new memory reads.
- `pc_reset`, input, 1: soft restart; PC becomes `RESET_VEC`.
- `pc_branch`, input, 1: redirect; PC becomes `branch_target`.
- `branch_target`, input, `ADDR_W`: redirect address, sampled while `pc_branch` is high.
- `mem_rd_en`, output, 1: read strobe to instruction memory.
- `mem_addr`, output, `ADDR_W`: read address.
- `mem_rdata`, input, 8: read data, valid exactly one cycle after `mem_rd_en`.
- `instr`, output, 24: assembled instruction. Byte0 is in [23:16], byte1 in [15:8], byte2 in [7:0]. Unused bytes read as 0.
- `instr_len`, output, 2: instruction length, 1, 2 or 3.
- `instr_pc`, output, `ADDR_W`: address of byte0.
- `instr_valid`, output, 1: `instr`, `instr_len` and `instr_pc` are valid.
- `instr_ack`, input, 1: decoder consumes the instruction.

## Operation
- Length is decoded from byte0[7:6]: 2'b11 gives 3 bytes, 2'b10 gives 2 bytes, anything else gives 1 byte.
- `pc` always points to the next byte to read. It increments by 1 per issued read and wraps modulo 2^`ADDR_W`.
- A `rd_pending` flag marks a read issued last cycle. Its data is captured into the current byte slot.
- States:
  - IDLE: entered after reset or `pc_reset`. Moves to BYTE0 on the next cycle.
  - BYTE0: issue a read at `pc` when `ifetch_en` is high, and latch `instr_pc` = `pc`.
  - BYTE1 and BYTE2: on byte0 or byte1 return, if more bytes are needed and `ifetch_en` is high, issue the next read in the same cycle. The length is taken combinationally from `mem_rdata`.
  - HOLD: after the last byte is captured, `instr_valid` is 1. On `instr_valid && instr_ack`, drop valid. If `ifetch_en` is high, issue the next byte0 read in that same cycle; otherwise go to BYTE0.
- `ifetch_en` low: no new `mem_rd_en`. A pending return is still captured. The FSM waits in place.
- `pc_branch`, in any state except IDLE:
  - `pc` becomes `branch_target`.
  - Any pending return is discarded.
  - `instr_valid` is cleared.
  - Next state is BYTE0.
  - No read is issued in the branch cycle.
- `pc_reset`: same as `pc_branch` but with `RESET_VEC`, and next state is IDLE.
- Priority: `reset` > `pc_reset` > `pc_branch` > `instr_ack` > normal progress.
- `instr_ack` while `instr_valid` is 0 is ignored.

## Timing
- Reset values:
  - `pc` = `RESET_VEC`; state = IDLE.
  - `mem_rd_en` = 0; `mem_addr` = `RESET_VEC`.
  - `instr` = 0; `instr_len` = 1; `instr_pc` = `RESET_VEC`.
  - `instr_valid` = 0; `rd_pending` = 0.
- `mem_addr` and `mem_rd_en` are combinational from state, `pc` and `mem_rdata`. All other outputs are registered.
- Latency, with byte0 issued in cycle t and `ifetch_en` held high:
  - 1-byte instruction: `instr_valid` in t+2.
  - 2-byte instruction: `instr_valid` in t+3.
  - 3-byte instruction: `instr_valid` in t+4.
- Back-to-back throughput with `instr_ack` held high is len+1 cycles per instruction.
- `pc_branch` in cycle t: the first read at `branch_target` is in t+1.
- `pc_reset` in cycle t: the first read at `RESET_VEC` is in t+2, because of the IDLE cycle.
- An asynchronous `reset` in mid-fetch clears state immediately. The memory return after deassertion is ignored, because `rd_pending` = 0.
- PC wrap: a read at 2^`ADDR_W`-1 is followed by a read at 0 within the same instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - fetch state encodings: IDLE, BYTE0, BYTE1, BYTE2, HOLD;
  - length-field constants: `LEN_FIELD_3B` = 2'b11, `LEN_FIELD_2B` = 2'b10.
- One natural sub-module: `cpu_ilen_decode`, a combinational byte0 → length decoder. The decoder stage reuses it.

## Test plan
- Reset: memory holds 0x05 at 0. Release `reset` with `ifetch_en`=1 → read at 0 in the cycle after IDLE; two cycles later `instr`=0x050000, `instr_len`=1, `instr_pc`=0.
- 3-byte instruction: bytes 0xC1 0x12 0x34 at 0x010, `instr_ack` held high → reads at 0x010, 0x011, 0x012 on consecutive cycles; `instr`=0xC11234, `instr_len`=3, valid 4 cycles after the first read; the next read is at 0x013.
- Branch mid-fetch: `pc_branch` with `branch_target`=0x200 while byte1 of a 2-byte instruction is pending → return discarded, no `instr_valid`, next read at 0x200.
- Stall: drop `ifetch_en` after byte0 (0x80) of a 2-byte instruction → no `mem_rd_en` while low, byte0 retained; re-raise → byte1 read issued, `instr_len`=2.
- Wrap: `ADDR_W`=12, 3-byte instruction at 0xFFE → reads at 0xFFE, 0xFFF, 0x000; `instr_pc`=0xFFE.
- Simultaneous events: `pc_reset` and `pc_branch` in the same cycle as `instr_ack` → reset wins; `instr_valid`=0, IDLE, next read at `RESET_VEC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch state encodings and length-field constants
//
// Holds the instruction fetch FSM states and the byte0[7:6] length-field
// codes shared by the fetch unit and the decoder stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BYTE0 = 3'd1,
        BYTE1 = 3'd2,
        BYTE2 = 3'd3,
        HOLD  = 3'd4
    } fetch_state_e;

    localparam logic [1:0] LEN_FIELD_3B = 2'b11;
    localparam logic [1:0] LEN_FIELD_2B = 2'b10;

endpackage

// File: rtl/cpu_ilen_decode.sv
// rtl/cpu_ilen_decode.sv - combinational byte0 to instruction length decoder
//
// Ports:
//   byte0_i : first instruction byte
//   len_o   : instruction length in bytes (1, 2 or 3)
module cpu_ilen_decode
    import cpu_pkg::*;
(
    input  logic [7:0] byte0_i,
    output logic [1:0] len_o
);

    always_comb begin
        case (byte0_i[7:6])
            LEN_FIELD_3B: len_o = 2'd3;
            LEN_FIELD_2B: len_o = 2'd2;
            default:      len_o = 2'd1;
        endcase
    end

endmodule

// File: rtl/cpu_ifetch.sv
// rtl/cpu_ifetch.sv - instruction fetch unit assembling 1-3 byte instructions
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   ifetch_en             : permission to issue new memory reads
//   pc_reset              : soft restart to RESET_VEC (through IDLE)
//   pc_branch, branch_target : redirect fetch to branch_target
//   mem_rd_en, mem_addr   : combinational read request to instruction memory
//   mem_rdata             : read data, one cycle after mem_rd_en
//   instr, instr_len, instr_pc, instr_valid : registered instruction to decoder
//   instr_ack             : decoder consumes the instruction
module cpu_ifetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifetch_en,
    input  logic              pc_reset,
    input  logic              pc_branch,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [23:0]       instr,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ack
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              rd_pending_q, rd_pending_d;
    // Slot (1 or 2) that the next return in BYTE2 fills.
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       instr_q, instr_d;
    logic [1:0]        len_q, len_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;
    logic              rd_en;
    logic [1:0]        rdata_len;

    // Length of the byte arriving now; only meaningful in BYTE1.
    cpu_ilen_decode u_len (
        .byte0_i (mem_rdata),
        .len_o   (rdata_len)
    );

    // Read issue: BYTE1 receives byte0 and may chain the byte1 read in the
    // same cycle; BYTE2 either issues a stalled read or chains the next one.
    always_comb begin
        rd_en = 1'b0;
        case (state_q)
            BYTE0:   rd_en = ifetch_en;
            BYTE1:   rd_en = ifetch_en && (rdata_len != 2'd1);
            BYTE2:   rd_en = ifetch_en && (!rd_pending_q || ((idx_q + 2'd1) < len_q));
            HOLD:    rd_en = ifetch_en && valid_q && instr_ack;
            default: rd_en = 1'b0;
        endcase
        if (pc_reset || pc_branch) begin
            rd_en = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = rd_en ? (pc_q + ADDR_W'(1)) : pc_q;
        rd_pending_d = rd_pending_q;
        idx_d        = idx_q;
        instr_d      = instr_q;
        len_d        = len_q;
        ipc_d        = ipc_q;
        valid_d      = valid_q;

        case (state_q)
            IDLE: begin
                state_d      = BYTE0;
                rd_pending_d = 1'b0;
            end
            BYTE0: begin
                if (rd_en) begin
                    state_d      = BYTE1;
                    rd_pending_d = 1'b1;
                    ipc_d        = pc_q;
                end
            end
            BYTE1: begin
                // A byte0 read is always outstanding in this state.
                instr_d = {mem_rdata, 16'h0000};
                len_d   = rdata_len;
                idx_d   = 2'd1;
                if (rdata_len == 2'd1) begin
                    state_d      = HOLD;
                    valid_d      = 1'b1;
                    rd_pending_d = 1'b0;
                end else begin
                    state_d      = BYTE2;
                    rd_pending_d = rd_en;
                end
            end
            BYTE2: begin
                if (rd_pending_q) begin
                    if (idx_q == 2'd1) begin
                        instr_d[15:8] = mem_rdata;
                    end else begin
                        instr_d[7:0] = mem_rdata;
                    end
                    if ((idx_q + 2'd1) == len_q) begin
                        state_d      = HOLD;
                        valid_d      = 1'b1;
                        rd_pending_d = 1'b0;
                    end else begin
                        idx_d        = idx_q + 2'd1;
                        rd_pending_d = rd_en;
                    end
                end else begin
                    rd_pending_d = rd_en;
                end
            end
            HOLD: begin
                if (valid_q && instr_ack) begin
                    valid_d = 1'b0;
                    if (rd_en) begin
                        state_d      = BYTE1;
                        rd_pending_d = 1'b1;
                        ipc_d        = pc_q;
                    end else begin
                        state_d = BYTE0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirects discard any return arriving this cycle.
        if (pc_reset) begin
            state_d      = IDLE;
            pc_d         = RESET_VEC;
            rd_pending_d = 1'b0;
            valid_d      = 1'b0;
            instr_d      = instr_q;
            len_d        = len_q;
            idx_d        = idx_q;
            ipc_d        = ipc_q;
        end else if (pc_branch && (state_q != IDLE)) begin
            state_d      = BYTE0;
            pc_d         = branch_target;
            rd_pending_d = 1'b0;
            valid_d      = 1'b0;
            instr_d      = instr_q;
            len_d        = len_q;
            idx_d        = idx_q;
            ipc_d        = ipc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VEC;
            rd_pending_q <= 1'b0;
            idx_q        <= 2'd0;
            instr_q      <= 24'h000000;
            len_q        <= 2'd1;
            ipc_q        <= RESET_VEC;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rd_pending_q <= rd_pending_d;
            idx_q        <= idx_d;
            instr_q      <= instr_d;
            len_q        <= len_d;
            ipc_q        <= ipc_d;
            valid_q      <= valid_d;
        end
    end

    assign mem_rd_en   = rd_en;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_len   = len_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_cpu_ifetch.sv
// tb/tb_cpu_ifetch.sv - self-checking bench for cpu_ifetch with reference model
module tb_cpu_ifetch;

    localparam int             AW = 12;
    localparam logic [AW-1:0]  RV = 12'h000;

    logic          clk = 1'b0;
    logic          reset;
    logic          ifetch_en;
    logic          pc_reset;
    logic          pc_branch;
    logic [AW-1:0] branch_target;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [23:0]   instr;
    logic [1:0]    instr_len;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ack;

    cpu_ifetch #(.ADDR_W(AW), .RESET_VEC(RV)) dut (
        .clk           (clk),
        .reset         (reset),
        .ifetch_en     (ifetch_en),
        .pc_reset      (pc_reset),
        .pc_branch     (pc_branch),
        .branch_target (branch_target),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr         (instr),
        .instr_len     (instr_len),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ack     (instr_ack)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];
    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;
    int n_hs     = 0;

    // Synchronous memory; junk on idle cycles so stale data is never trusted.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= 8'($urandom);
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    int            rd_cyc [$];
    logic [AW-1:0] rd_adr [$];
    int            v_cyc  [$];
    logic [23:0]   v_ins  [$];
    logic [1:0]    v_len  [$];
    logic [AW-1:0] v_pc   [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_len(input logic [7:0] b);
        if (b[7:6] == 2'b11) return 3;
        if (b[7:6] == 2'b10) return 2;
        return 1;
    endfunction

    function automatic logic [23:0] m_instr(input logic [AW-1:0] a);
        logic [AW-1:0] a1 = a + 12'd1;
        logic [AW-1:0] a2 = a + 12'd2;
        logic [23:0]   r  = {mem[a], 16'h0000};
        int            l  = m_len(mem[a]);
        if (l >= 2) r[15:8] = mem[a1];
        if (l == 3) r[7:0]  = mem[a2];
        return r;
    endfunction

    function automatic int rdc(input int i); return (i < rd_cyc.size()) ? rd_cyc[i] : -1000; endfunction
    function automatic int rda(input int i); return (i < rd_adr.size()) ? int'(rd_adr[i]) : -1; endfunction
    function automatic int vc(input int i);  return (i < v_cyc.size()) ? v_cyc[i] : -1000; endfunction
    function automatic int vi(input int i);  return (i < v_ins.size()) ? int'(v_ins[i]) : -1; endfunction
    function automatic int vl(input int i);  return (i < v_len.size()) ? int'(v_len[i]) : -1; endfunction
    function automatic int vp(input int i);  return (i < v_pc.size()) ? int'(v_pc[i]) : -1; endfunction

    task automatic clear_logs();
        rd_cyc.delete(); rd_adr.delete();
        v_cyc.delete(); v_ins.delete(); v_len.delete(); v_pc.delete();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max);
        int k = 0;
        while (v_cyc.size() == 0 && k < max) begin
            next();
            k++;
        end
        chk({name, "_valid_seen"}, int'(v_cyc.size() > 0), 1);
    endtask

    task automatic branch_to(input logic [AW-1:0] a, output int bc);
        pc_branch     = 1'b1;
        branch_target = a;
        bc            = cyc_n;
        next();
        pc_branch     = 1'b0;
        clear_logs();
    endtask

    // Reference model: expected next read address and start of the next
    // instruction, advanced by handshakes and redirects.
    initial begin
        logic [AW-1:0] m_rd, m_ipc;
        bit            m_idle, m_redir, vprev;
        m_rd = RV; m_ipc = RV; m_idle = 1'b1; m_redir = 1'b0; vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_rd_en", int'(mem_rd_en), 0);
                chk("rst_mem_addr", int'(mem_addr), int'(RV));
                chk("rst_instr", int'(instr), 0);
                chk("rst_instr_len", int'(instr_len), 1);
                chk("rst_instr_pc", int'(instr_pc), int'(RV));
                chk("rst_valid", int'(instr_valid), 0);
                m_rd = RV; m_ipc = RV; m_idle = 1'b1; m_redir = 1'b0; vprev = 1'b0;
            end else begin
                if (m_redir) chk("valid_after_redirect", int'(instr_valid), 0);
                if (mem_rd_en) begin
                    chk("rd_while_disabled", int'(ifetch_en), 1);
                    chk("rd_in_redirect", int'(pc_branch || pc_reset), 0);
                    chk("rd_addr", int'(mem_addr), int'(m_rd));
                    rd_cyc.push_back(cyc_n);
                    rd_adr.push_back(mem_addr);
                    m_rd = m_rd + 12'd1;
                end
                if (instr_valid) begin
                    chk("instr", int'(instr), int'(m_instr(m_ipc)));
                    chk("instr_len", int'(instr_len), m_len(mem[m_ipc]));
                    chk("instr_pc", int'(instr_pc), int'(m_ipc));
                    if (!vprev) begin
                        v_cyc.push_back(cyc_n); v_ins.push_back(instr);
                        v_len.push_back(instr_len); v_pc.push_back(instr_pc);
                    end
                end
                vprev   = instr_valid;
                m_redir = 1'b0;
                if (pc_reset) begin
                    m_rd = RV; m_ipc = RV; m_redir = 1'b1; m_idle = 1'b1;
                end else if (pc_branch && !m_idle) begin
                    m_rd = branch_target; m_ipc = branch_target; m_redir = 1'b1; m_idle = 1'b0;
                end else begin
                    if (instr_valid && instr_ack) begin
                        m_ipc = m_ipc + 12'(m_len(mem[m_ipc]));
                        n_hs++;
                    end
                    m_idle = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b, c0, s;
        reset = 1'b1; ifetch_en = 1'b1; pc_reset = 1'b0; pc_branch = 1'b0;
        branch_target = '0; instr_ack = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'h05;
        mem[12'h010] = 8'hC1; mem[12'h011] = 8'h12; mem[12'h012] = 8'h34;
        mem[12'h100] = 8'h80; mem[12'h101] = 8'h55;
        mem[12'h200] = 8'h01;
        mem[12'h300] = 8'h80; mem[12'h301] = 8'h77;
        mem[12'hFFE] = 8'hC0; mem[12'hFFF] = 8'hAB;
        repeat (3) next();

        // Reset release, 1-byte instruction at 0
        reset = 1'b0; c0 = cyc_n; clear_logs();
        wait_valid("t1", 10);
        chk("t1_rd0_cyc", rdc(0) - c0, 1);
        chk("t1_rd0_addr", rda(0), 12'h000);
        chk("t1_valid_cyc", vc(0) - c0, 3);
        chk("t1_instr", vi(0), 24'h050000);
        chk("t1_len", vl(0), 1);
        chk("t1_pc", vp(0), 12'h000);
        repeat (3) next();
        chk("t1_hold_no_reads", rd_cyc.size(), 1);

        // 3-byte instruction, ack held high
        instr_ack = 1'b1;
        branch_to(12'h010, b);
        wait_valid("t2", 12);
        chk("t2_rd0", rda(0), 12'h010); chk("t2_rd0_cyc", rdc(0) - b, 1);
        chk("t2_rd1", rda(1), 12'h011); chk("t2_rd1_cyc", rdc(1) - b, 2);
        chk("t2_rd2", rda(2), 12'h012); chk("t2_rd2_cyc", rdc(2) - b, 3);
        chk("t2_valid_cyc", vc(0) - rdc(0), 4);
        chk("t2_instr", vi(0), 24'hC11234);
        chk("t2_len", vl(0), 3);
        chk("t2_next_rd", rda(3), 12'h013);
        chk("t2_next_rd_cyc", rdc(3) - vc(0), 0);

        // Branch while byte1 of a 2-byte instruction is pending
        branch_to(12'h100, b);
        next(); next();
        pc_branch = 1'b1; branch_target = 12'h200;
        next();
        pc_branch = 1'b0;
        wait_valid("t3", 12);
        chk("t3_rd0", rda(0), 12'h100); chk("t3_rd0_cyc", rdc(0) - b, 1);
        chk("t3_rd1", rda(1), 12'h101); chk("t3_rd1_cyc", rdc(1) - b, 2);
        chk("t3_rd2", rda(2), 12'h200); chk("t3_rd2_cyc", rdc(2) - b, 4);
        chk("t3_valid_cyc", vc(0) - b, 6);
        chk("t3_pc", vp(0), 12'h200);
        chk("t3_instr", vi(0), 24'h010000);

        // Stall after byte0 of a 2-byte instruction
        instr_ack = 1'b0;
        branch_to(12'h300, b);
        next();
        ifetch_en = 1'b0;
        repeat (4) next();
        ifetch_en = 1'b1;
        wait_valid("t4", 12);
        chk("t4_rd0", rda(0), 12'h300); chk("t4_rd0_cyc", rdc(0) - b, 1);
        chk("t4_rd1", rda(1), 12'h301); chk("t4_rd1_cyc", rdc(1) - b, 6);
        chk("t4_valid_cyc", vc(0) - b, 8);
        chk("t4_instr", vi(0), 24'h807700);
        chk("t4_len", vl(0), 2);

        // PC wrap inside a 3-byte instruction
        branch_to(12'hFFE, b);
        wait_valid("t5", 12);
        chk("t5_rd0", rda(0), 12'hFFE);
        chk("t5_rd1", rda(1), 12'hFFF);
        chk("t5_rd2", rda(2), 12'h000); chk("t5_rd2_cyc", rdc(2) - b, 3);
        chk("t5_pc", vp(0), 12'hFFE);
        chk("t5_instr", vi(0), 24'hC0AB05);
        chk("t5_valid_cyc", vc(0) - b, 5);

        // pc_reset + pc_branch + instr_ack together: reset wins
        pc_reset = 1'b1; pc_branch = 1'b1; branch_target = 12'h123; instr_ack = 1'b1;
        s = cyc_n;
        next();
        pc_reset = 1'b0; pc_branch = 1'b0;
        clear_logs();
        chk("t6_valid_cleared", int'(instr_valid), 0);
        wait_valid("t6", 12);
        chk("t6_rd0", rda(0), int'(RV)); chk("t6_rd0_cyc", rdc(0) - s, 2);
        chk("t6_pc", vp(0), int'(RV));
        chk("t6_valid_cyc", vc(0) - s, 4);

        // Randomized run against the model
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        next(); next();
        reset = 1'b0;
        n_hs = 0;
        for (int i = 0; i < 4000; i++) begin
            ifetch_en     = ($urandom_range(0, 9) < 8);
            instr_ack     = ($urandom_range(0, 9) < 6);
            pc_branch     = ($urandom_range(0, 39) == 0);
            pc_reset      = ($urandom_range(0, 119) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? (12'hFFD + 12'($urandom_range(0, 2)))
                                                        : 12'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #3;
                reset = 1'b1;
                #1;
                chk("async_rst_valid", int'(instr_valid), 0);
                chk("async_rst_rd_en", int'(mem_rd_en), 0);
                next();
                reset = 1'b0;
            end else begin
                next();
            end
        end
        pc_branch = 1'b0; pc_reset = 1'b0;
        chk("random_progress", int'(n_hs > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
